// File: rtl/latch_pkg.sv
// latch_pkg: shared definitions for the clocked SR latch bank.
//   - S=R=1 resolution mode encodings.
//   - req_t: one channel's effective request for a single clock edge.
//   - resolve_req(): maps a raw (s, r) pair and the resolution mode onto req_t.
package latch_pkg;

  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_HOLD    = 2;
  localparam int MODE_TOGGLE  = 3;

  typedef struct packed {
    logic set;        // drive q high
    logic reset_req;  // ask for q low (the dwell may defer it)
    logic toggle;     // invert q; the cell turns this into set or reset_req
  } req_t;

  // Leaves at most one field set. A toggle is kept separate because its
  // direction depends on the current q, which the cell owns.
  function automatic req_t resolve_req(input logic s, input logic r, input int mode);
    req_t req;
    req = '0;
    unique case ({s, r})
      2'b10: req.set       = 1'b1;
      2'b01: req.reset_req = 1'b1;
      2'b11: begin
        unique case (mode)
          MODE_RST_DOM: req.reset_req = 1'b1;
          MODE_SET_DOM: req.set       = 1'b1;
          MODE_TOGGLE:  req.toggle    = 1'b1;
          default:      ;  // MODE_HOLD: no change
        endcase
      end
      default: ;  // 2'b00: hold
    endcase
    return req;
  endfunction

endpackage

// File: rtl/latch_sr_cell.sv
// latch_sr_cell: one channel of the latch bank.
// It holds the latched state, the minimum-on dwell counter, the deferred
// (pending) reset and the sticky conflict flag.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   s, r      set / reset request, sampled each edge
//   clr_err   clears the conflict flag
//   q         registered latch state
//   conflict  sticky flag: s and r were seen high together
//   q_next    next-state of q, used for the bank's registered any_q
module latch_sr_cell
  import latch_pkg::*;
#(
  parameter int MODE   = MODE_RST_DOM,
  parameter int MIN_ON = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic q,
  output logic conflict,
  output logic q_next
);

  localparam int             CW       = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MIN_ON);

  logic          q_q, q_d;
  logic          pend_q, pend_d;
  logic          conf_q, conf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_dec;
  logic          lock;
  logic          set_eff, rreq_eff;
  req_t          req;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the if/else chain can leave it unassigned and infer a latch.
    req      = resolve_req(s, r, MODE);
    set_eff  = req.set       | (req.toggle & ~q_q);
    rreq_eff = req.reset_req | (req.toggle &  q_q);

    // The counter is loaded with MIN_ON on the rising edge of q. Lock is
    // judged on the value after this edge's decrement, so q is held high
    // for MIN_ON cycles in total before a reset may take effect.
    cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    lock    = (cnt_dec != '0);

    q_d    = q_q;
    pend_d = pend_q;
    cnt_d  = cnt_dec;

    if (set_eff) begin
      q_d    = 1'b1;
      pend_d = 1'b0;               // a set cancels a deferred reset
      if (!q_q) cnt_d = CNT_LOAD;  // only a 0->1 transition restarts the dwell
    end else if (rreq_eff) begin
      if (lock) begin
        pend_d = 1'b1;
      end else begin
        q_d    = 1'b0;
        pend_d = 1'b0;
      end
    end else if (pend_q && !lock) begin
      q_d    = 1'b0;
      pend_d = 1'b0;
    end

    // A fresh conflict wins over a simultaneous clear.
    conf_d = (s & r) | (conf_q & ~clr_err);
  end

  // NOTE: reset is synchronous here: it is sampled only at the clock edge,
  // so it must be held across an edge to take effect.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      q_q    <= 1'b0;
      pend_q <= 1'b0;
      conf_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      pend_q <= pend_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q        = q_q;
  assign conflict = conf_q;
  assign q_next   = q_d;

endmodule

// File: rtl/latch_sr_bank.sv
// latch_sr_bank: CHANNELS independent clocked SR latches with a selectable
// S=R=1 resolution, a minimum-on dwell, a deferred reset and sticky conflict
// flags. It sits between keypad/sensor decode and the magnetron enable logic.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   s, r      per-channel set / reset requests
//   clr_err   clears all conflict flags
//   q         registered latch states
//   conflict  per-channel sticky s&r flags
//   any_q     registered OR of the next-state q, aligned with q
module latch_sr_bank
  import latch_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RST_DOM,
  parameter int MIN_ON   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic                clr_err,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] conflict,
  output logic                any_q
);

  logic [CHANNELS-1:0] q_next;
  logic                any_q_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    latch_sr_cell #(
      .MODE  (MODE),
      .MIN_ON(MIN_ON)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .r       (r[i]),
      .clr_err (clr_err),
      .q       (q[i]),
      .conflict(conflict[i]),
      .q_next  (q_next[i])
    );
  end

  // Registered from the cells' next state so any_q changes on the same edge as q.
  always_ff @(posedge clk) begin
    if (rst) any_q_q <= 1'b0;
    else     any_q_q <= |q_next;
  end

  assign any_q = any_q_q;

endmodule

// File: tb/tb_latch_sr_bank.sv
// Testbench for latch_sr_bank. It runs five instances side by side:
// MODE 0..3 with MIN_ON=3, plus MODE 0 with MIN_ON=0. Every stimulus cycle
// pushes the expected post-edge outputs into a queue. A monitor pops one
// entry after each clock edge and compares it. The reference model tracks
// the edge at which each channel rose, instead of modelling a down-counter.
module tb_latch_sr_bank;

  localparam int ND = 5;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_err;
  logic [CH-1:0] s, r;

  logic [CH-1:0] q_w    [ND];
  logic [CH-1:0] conf_w [ND];
  logic          any_w  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    latch_sr_bank #(
      .CHANNELS(CH),
      .MODE    ((g < 4) ? g : 0),
      .MIN_ON  ((g < 4) ? 3 : 0)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .s       (s),
      .r       (r),
      .clr_err (clr_err),
      .q       (q_w[g]),
      .conflict(conf_w[g]),
      .any_q   (any_w[g])
    );
  end

  typedef struct packed {
    logic [CH-1:0] q;
    logic [CH-1:0] conf;
    logic          any;
  } obs_t;
  typedef obs_t [ND-1:0] snap_t;

  snap_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [CH-1:0] m_q    [ND];
  bit [CH-1:0] m_pend [ND];
  bit [CH-1:0] m_conf [ND];
  bit          m_any  [ND];
  int          m_rise [ND][CH];
  int          edge_n = 0;

  function automatic int mode_of(int d);
    return (d < 4) ? d : 0;
  endfunction

  function automatic int minon_of(int d);
    return (d < 4) ? 3 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One edge of the behavioural model. A channel is locked while it is high
  // and fewer than MIN_ON edges have passed since the edge at which it rose.
  function automatic void model_edge(input bit rst_v, input bit [CH-1:0] s_v,
                                     input bit [CH-1:0] r_v, input bit clr_v);
    for (int d = 0; d < ND; d++) begin
      if (rst_v) begin
        m_q[d] = '0; m_pend[d] = '0; m_conf[d] = '0; m_any[d] = 1'b0;
      end else begin
        for (int i = 0; i < CH; i++) begin
          bit do_set, do_rst, locked;
          do_set = 0; do_rst = 0;
          if (s_v[i] && !r_v[i])      do_set = 1;
          else if (!s_v[i] && r_v[i]) do_rst = 1;
          else if (s_v[i] && r_v[i]) begin
            case (mode_of(d))
              0: do_rst = 1;
              1: do_set = 1;
              3: if (m_q[d][i]) do_rst = 1; else do_set = 1;
              default: ;
            endcase
          end
          locked = m_q[d][i] && ((edge_n - m_rise[d][i]) < minon_of(d));
          if (do_set) begin
            if (!m_q[d][i]) m_rise[d][i] = edge_n;
            m_q[d][i] = 1; m_pend[d][i] = 0;
          end else if (do_rst) begin
            if (locked) m_pend[d][i] = 1;
            else begin m_q[d][i] = 0; m_pend[d][i] = 0; end
          end else if (m_pend[d][i] && !locked) begin
            m_q[d][i] = 0; m_pend[d][i] = 0;
          end
          m_conf[d][i] = (s_v[i] & r_v[i]) | (m_conf[d][i] & ~clr_v);
        end
        m_any[d] = |m_q[d];
      end
    end
    edge_n++;
  endfunction

  // Drive one cycle from a negedge, record the expectation, return at the next negedge.
  task automatic cyc(input logic rst_v, input logic [CH-1:0] s_v,
                     input logic [CH-1:0] r_v, input logic clr_v);
    snap_t snap;
    rst = rst_v; s = s_v; r = r_v; clr_err = clr_v;
    model_edge(rst_v, s_v, r_v, clr_v);
    for (int d = 0; d < ND; d++) begin
      snap[d].q    = m_q[d];
      snap[d].conf = m_conf[d];
      snap[d].any  = m_any[d];
    end
    exp_q.push_back(snap);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: the outputs are valid every cycle, so compare just after each edge.
  initial begin
    snap_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        for (int d = 0; d < ND; d++) begin
          check($sformatf("dut%0d_q", d),        q_w[d],    got[d].q);
          check($sformatf("dut%0d_conflict", d), conf_w[d], got[d].conf);
          check($sformatf("dut%0d_any_q", d),    any_w[d],  got[d].any);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[4];
    tbl = '{0, 1, 0, 1};
    rst = 1'b1; s = '0; r = '0; clr_err = 1'b0;
    @(negedge clk);

    // 1: reset overrides set requests
    cyc(1'b1, 4'hF, '0, 1'b0);
    cyc(1'b1, 4'hF, '0, 1'b0);
    for (int d = 0; d < ND; d++) check($sformatf("rst_q_dut%0d", d), q_w[d], 0);
    idle(2);
    for (int d = 0; d < ND; d++) check($sformatf("post_rst_q_dut%0d", d), q_w[d], 0);

    // 2: plain set/hold/reset, no dwell
    cyc(1'b0, 4'b0001, '0, 1'b0);
    check("nodwell_set_q", q_w[4][0], 1);
    check("nodwell_set_any", any_w[4], 1);
    idle(2);
    check("nodwell_hold_q", q_w[4][0], 1);
    cyc(1'b0, '0, 4'b0001, 1'b0);
    check("nodwell_rst_q", q_w[4][0], 0);
    check("nodwell_rst_any", any_w[4], 0);

    // 3: S=R=1 resolution per mode, conflict flag and its clear
    cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("mode%0d_sr_q", d), q_w[d][1], tbl[d]);
      check($sformatf("mode%0d_conflict", d), conf_w[d][1], 1);
    end
    cyc(1'b0, '0, '0, 1'b1);
    for (int d = 0; d < 4; d++) check($sformatf("mode%0d_clr", d), conf_w[d][1], 0);
    cyc(1'b0, 4'b0010, 4'b0010, 1'b1);
    for (int d = 0; d < 4; d++) check($sformatf("mode%0d_clr_vs_new", d), conf_w[d][1], 1);

    // 4: a reset during the dwell is deferred until the dwell ends
    cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b0, 4'b0100, '0, 1'b0);           // edge 0
    cyc(1'b0, '0, 4'b0100, 1'b0);           // edge 1
    check("dwell_e1_q", q_w[0][2], 1);
    idle(1);                                // edge 2
    check("dwell_e2_q", q_w[0][2], 1);
    idle(1);                                // edge 3
    check("dwell_e3_q", q_w[0][2], 0);

    // 5: a set cancels the pending reset
    cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b0, 4'b0100, '0, 1'b0);
    cyc(1'b0, '0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, '0, 1'b0);
    idle(4);
    check("cancel_hold_q", q_w[0][2], 1);
    cyc(1'b0, '0, 4'b0100, 1'b0);
    check("cancel_late_rst_q", q_w[0][2], 0);

    // 6: reset mid-dwell with a pending reset, then a full fresh dwell
    cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b0, 4'b0100, '0, 1'b0);
    cyc(1'b0, '0, 4'b0100, 1'b0);
    cyc(1'b1, '0, '0, 1'b0);
    for (int d = 0; d < ND; d++) check($sformatf("midrst_q_dut%0d", d), q_w[d], 0);
    cyc(1'b0, 4'b0100, '0, 1'b0);
    cyc(1'b0, '0, 4'b0100, 1'b0);
    idle(1);
    check("fresh_dwell_e2_q", q_w[0][2], 1);
    idle(1);
    check("fresh_dwell_e3_q", q_w[0][2], 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(63) == 0), CH'($urandom & $urandom), CH'($urandom & $urandom),
          ($urandom_range(7) == 0));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
